// File: rtl/prog_loader.sv
// prog_loader: 16 x 8 writable program store loaded over a UART 8N1 line.
// Holds the CPU halted (cpu_run = 0) until a complete image has been received.
// Optional build macro: PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [3:0] addr,
    output logic [7:0] data,
    output logic       cpu_run,
    output logic       loading,
    output logic       err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, RUN} ld_state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, RUN} ld_state_t;
`endif

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t   rx_state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_byte_q;
    logic        byte_valid_q;
    logic        frame_err_q;

    ld_state_t   ld_state_q;
    logic [3:0]  ptr_q;
    logic [7:0]  mem_q [16];
    logic        cpu_run_q;
    logic        loading_q;
    logic        err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q;
`endif

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Byte receiver: mid-bit sampling, emits one-cycle byte_valid / frame_err pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                        bit_q <= bit_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q      <= '0;
                        rx_byte_q  <= shift_q;
                        byte_valid_q <= rx_sync_q;
                        frame_err_q  <= !rx_sync_q;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Load controller: sync detection, image write, CPU release and error tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_state_q <= IDLE;
            ptr_q      <= '0;
            cpu_run_q  <= 1'b0;
            loading_q  <= 1'b0;
            err_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
            for (int unsigned i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else if (byte_valid_q) begin
            case (ld_state_q)
                IDLE, RUN: begin
                    if (rx_byte_q == SYNC_BYTE) begin
                        ld_state_q <= LOAD;
                        ptr_q      <= '0;
                        cpu_run_q  <= 1'b0;
                        loading_q  <= 1'b1;
                        err_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_q      <= '0;
`endif
                    end
                end
                LOAD: begin
                    mem_q[ptr_q] <= rx_byte_q;
                    ptr_q        <= ptr_q + 4'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_q <= sum_q + rx_byte_q;
                    if (ptr_q == 4'hF) begin
                        ld_state_q <= CHECK;
                    end
`else
                    if (ptr_q == 4'hF) begin
                        ld_state_q <= RUN;
                        loading_q  <= 1'b0;
                        cpu_run_q  <= 1'b1;
                    end
`endif
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHECK: begin
                    loading_q <= 1'b0;
                    if (rx_byte_q == sum_q) begin
                        ld_state_q <= RUN;
                        cpu_run_q  <= 1'b1;
                    end else begin
                        ld_state_q <= IDLE;
                        err_q      <= 1'b1;
                    end
                end
`endif
                default: ld_state_q <= IDLE;
            endcase
        end else if (frame_err_q) begin
            // Abort only while an image is in flight; keep partial memory, CPU stays halted.
            case (ld_state_q)
`ifdef PROG_LOADER_CHECKSUM_EN
                LOAD, CHECK: begin
`else
                LOAD: begin
`endif
                    ld_state_q <= IDLE;
                    loading_q  <= 1'b0;
                    err_q      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign data    = mem_q[addr];
    assign cpu_run = cpu_run_q;
    assign loading = loading_q;
    assign err     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader (default build,
// checksum option off). Expected behaviour comes from a byte-level model of the
// loader rules, not from the receiver/controller structure.
module tb_prog_loader;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [3:0] addr;
    logic [7:0] data;
    logic       cpu_run;
    logic       loading;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: image contents plus the three visible status flags.
    logic [7:0]  m_mem [16];
    logic        m_run, m_loading, m_err;
    int unsigned m_ptr;

    prog_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .addr    (addr),
        .data    (data),
        .cpu_run (cpu_run),
        .loading (loading),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_run = 1'b0; m_loading = 1'b0; m_err = 1'b0; m_ptr = 0;
    endfunction

    // A good byte: sync starts a load when not loading; otherwise fill the image.
    function automatic void m_byte(input logic [7:0] b);
        if (!m_loading) begin
            if (b == 8'hA5) begin
                m_loading = 1'b1; m_run = 1'b0; m_err = 1'b0; m_ptr = 0;
            end
        end else begin
            m_mem[m_ptr] = b;
            if (m_ptr == 15) begin
                m_loading = 1'b0; m_run = 1'b1;
            end
            m_ptr = (m_ptr + 1) % 16;
        end
    endfunction

    function automatic void m_frame_err();
        if (m_loading) begin
            m_loading = 1'b0; m_err = 1'b1;
        end
    endfunction

    function automatic logic [7:0] rand_non_sync();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        return b;
    endfunction

    // Serialise one 8N1 frame (stop bit selectable) and update the model.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        if (stop) m_byte(b); else m_frame_err();
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; addr = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_run got %b want 0", cpu_run); end
        n_tests++;
        if (loading !== 1'b0) begin n_fail++; $display("FAIL reset_loading got %b want 0", loading); end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        for (int a = 0; a < 16; a++) begin
            addr = a[3:0]; #1;
            n_tests++;
            if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data addr=%0d got %h want 00", a, data); end
        end
    endtask

    task automatic test_load();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'h10 + 8'(i);
            n_tests++;
            if (loading !== 1'b1 || cpu_run !== 1'b0) begin
                n_fail++; $display("FAIL load_busy byte=%0d got loading=%b cpu_run=%b want 1/0", i, loading, cpu_run);
            end
            send_byte(b, 1'b1);
        end
        n_tests++;
        if (cpu_run !== m_run || loading !== m_loading) begin
            n_fail++; $display("FAIL load_done got cpu_run=%b loading=%b want %b/%b", cpu_run, loading, m_run, m_loading);
        end
        addr = 4'hF; #1;
        n_tests++;
        if (data !== 8'h1F) begin n_fail++; $display("FAIL load_data_F got %h want 1f", data); end
        for (int a = 0; a < 16; a++) begin
            addr = a[3:0]; #1;
            n_tests++;
            if (data !== m_mem[a]) begin n_fail++; $display("FAIL load_mem addr=%0d got %h want %h", a, data, m_mem[a]); end
        end
    endtask

    task automatic test_glitch();
        int unsigned k;
        for (int r = 0; r < 4; r++) begin
            k = $urandom_range(1, 5);
            @(negedge clk) rx = 1'b0;
            repeat (k) @(negedge clk);
            rx = 1'b1;
            repeat (3 * CPB) @(negedge clk);
            n_tests++;
            if (cpu_run !== m_run || loading !== m_loading || err !== m_err) begin
                n_fail++; $display("FAIL glitch len=%0d got run=%b load=%b err=%b want %b/%b/%b",
                                   k, cpu_run, loading, err, m_run, m_loading, m_err);
            end
        end
        // A non-sync byte while running must be ignored, glitches or not.
        send_byte(rand_non_sync(), 1'b1);
        addr = 4'($urandom_range(0, 15)); #1;
        n_tests++;
        if (cpu_run !== m_run || loading !== m_loading || data !== m_mem[addr]) begin
            n_fail++; $display("FAIL run_ignore got run=%b load=%b data=%h want %b/%b/%h",
                               cpu_run, loading, data, m_run, m_loading, m_mem[addr]);
        end
    endtask

    task automatic test_framing();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        n_tests++;
        if (err !== 1'b1 || cpu_run !== 1'b0 || loading !== 1'b0) begin
            n_fail++; $display("FAIL frame_err got err=%b run=%b load=%b want 1/0/0", err, cpu_run, loading);
        end
        for (int a = 0; a < 16; a++) begin
            addr = a[3:0]; #1;
            n_tests++;
            if (data !== m_mem[a]) begin n_fail++; $display("FAIL frame_partial addr=%0d got %h want %h", a, data, m_mem[a]); end
        end
        send_byte(rand_non_sync(), 1'b1);
        n_tests++;
        if (err !== 1'b1 || loading !== 1'b0) begin
            n_fail++; $display("FAIL frame_sticky got err=%b load=%b want 1/0", err, loading);
        end
        send_byte(8'hA5, 1'b1);
        n_tests++;
        if (err !== 1'b0 || loading !== 1'b1) begin
            n_fail++; $display("FAIL frame_clear got err=%b load=%b want 0/1", err, loading);
        end
        for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        n_tests++;
        if (cpu_run !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL frame_recover got run=%b err=%b want 1/0", cpu_run, err);
        end
    endtask

    task automatic test_reload();
        send_byte(8'hA5, 1'b1);
        n_tests++;
        if (cpu_run !== 1'b0 || loading !== 1'b1) begin
            n_fail++; $display("FAIL reload_start got run=%b load=%b want 0/1", cpu_run, loading);
        end
        for (int i = 0; i < 16; i++) send_byte(8'hFF, 1'b1);
        n_tests++;
        if (cpu_run !== 1'b1 || loading !== 1'b0) begin
            n_fail++; $display("FAIL reload_done got run=%b load=%b want 1/0", cpu_run, loading);
        end
        for (int a = 0; a < 16; a++) begin
            addr = a[3:0]; #1;
            n_tests++;
            if (data !== 8'hFF) begin n_fail++; $display("FAIL reload_data addr=%0d got %h want ff", a, data); end
        end
    endtask

    task automatic test_random_images();
        for (int r = 0; r < 2; r++) begin
            int unsigned sync_pos;
            sync_pos = $urandom_range(0, 15);
            send_byte(8'hA5, 1'b1);
            for (int i = 0; i < 16; i++) begin
                // Embed one sync value as ordinary image data.
                send_byte((i == int'(sync_pos)) ? 8'hA5 : 8'($urandom_range(0, 255)), 1'b1);
            end
            n_tests++;
            if (cpu_run !== m_run || loading !== m_loading || err !== m_err) begin
                n_fail++; $display("FAIL rand_status round=%0d got %b/%b/%b want %b/%b/%b",
                                   r, cpu_run, loading, err, m_run, m_loading, m_err);
            end
            for (int a = 0; a < 16; a++) begin
                addr = a[3:0]; #1;
                n_tests++;
                if (data !== m_mem[a]) begin n_fail++; $display("FAIL rand_mem round=%0d addr=%0d got %h want %h", r, a, data, m_mem[a]); end
            end
        end
    endtask

    task automatic test_reset_midload();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(1, 255)), 1'b1);
        @(negedge clk) reset = 1'b1;
        m_reset();
        #1;
        n_tests++;
        if (cpu_run !== 1'b0 || loading !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs got run=%b load=%b err=%b want 0/0/0", cpu_run, loading, err);
        end
        for (int a = 0; a < 16; a++) begin
            addr = a[3:0]; #1;
            n_tests++;
            if (data !== 8'h00) begin n_fail++; $display("FAIL midreset_mem addr=%0d got %h want 00", a, data); end
        end
        @(negedge clk) reset = 1'b0;
        send_byte(rand_non_sync(), 1'b1);
        n_tests++;
        if (cpu_run !== 1'b0 || loading !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL midreset_ignore got run=%b load=%b err=%b want 0/0/0", cpu_run, loading, err);
        end
        for (int a = 0; a < 16; a++) begin
            addr = a[3:0]; #1;
            n_tests++;
            if (data !== m_mem[a]) begin n_fail++; $display("FAIL midreset_after addr=%0d got %h want %h", a, data, m_mem[a]); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_glitch();
        test_framing();
        test_reload();
        test_random_images();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream program-memory stage for the 4-bit CPU. Replaces the fixed instruction ROM with a 16 x 8 writable program store loaded over a UART 8N1 serial line, and holds the CPU halted until a complete image has arrived. The CPU keeps its combinational fetch path: it presents a 4-bit address and reads an 8-bit instruction in the same cycle. The CPU's register reset is driven from `cpu_run`.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; minimum 4.
- `SYNC_BYTE`, 8'hA5: byte that starts an image load.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-high reset.
- `rx` in 1: serial input, idle high, asynchronous to `clk`.
- `addr` in 4: CPU fetch address.
- `data` out 8: instruction at `addr`, combinational read.
- `cpu_run` out 1: 1 = CPU released; 0 = CPU held in reset. Drives the CPU reset input (active-low at the CPU).
- `loading` out 1: high while an image is being received.
- `err` out 1: sticky load error; cleared on the next accepted sync byte.

## Operation
- Input synchroniser: `rx` passes through a 2-flop synchroniser. All logic uses the synchronised copy.
- Byte receiver FSM:
  - `RX_IDLE`: waits for a falling edge, then goes to `RX_START`.
  - `RX_START`: re-samples at `CLKS_PER_BIT/2`. If the line is high, the edge was a glitch; discard and return to `RX_IDLE`.
  - `RX_DATA`: samples 8 bits, LSB first, one every `CLKS_PER_BIT`, at mid-bit.
  - `RX_STOP`: samples the stop bit. 1 gives a one-cycle `byte_valid` pulse. 0 gives a one-cycle `frame_err` pulse.
  - After either pulse the receiver returns to `RX_IDLE`.
- Load FSM:
  - `IDLE`: `cpu_run`=0. `SYNC_BYTE` goes to `LOAD`, clears `err`, and sets the write pointer to 0. Any other byte is ignored.
  - `LOAD`: `loading`=1. Each valid byte is written to `mem[ptr]`, then `ptr` increments (4-bit).
    - After the write at `ptr`=15: go to `RUN`, or to `CHECK` if the checksum option is compiled in.
    - In `LOAD`, `SYNC_BYTE` is stored as ordinary data.
  - `CHECK` (option only): the next valid byte is compared with the checksum. Match goes to `RUN`. Mismatch sets `err` and goes to `IDLE`.
  - `RUN`: `cpu_run`=1. Receiving `SYNC_BYTE` drops `cpu_run`, clears `err`, resets `ptr`, and enters `LOAD`. Other bytes are ignored.
- `frame_err` in `LOAD` or `CHECK`: sets `err` and goes to `IDLE`. Partially written memory is kept and the CPU stays halted. `frame_err` in `IDLE` or `RUN` is ignored.
- Read path: `data = mem[addr]` at all times, including during a load.

## Timing
- Reset (asynchronous): all FSMs to idle states, `mem` cleared to 8'h00, `ptr`=0, `cpu_run`=0, `loading`=0, `err`=0, `data`=8'h00.
- Latency: `byte_valid` fires 2 (sync) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles after the start-bit falling edge reaches `rx`, ±1 cycle.
- Memory write, `ptr` update and state change all occur on the edge following the cycle in which `byte_valid` is high. Written data is visible on `data` the cycle after that edge.
- `cpu_run` rises on the clk edge after the last byte is accepted. It falls on the edge after `SYNC_BYTE` is accepted in `RUN`. It never glitches combinationally.
- `reset` asserted mid-byte or mid-load aborts immediately. There is no resume; the host resends the whole image.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - Adds the `CHECK` state and an 8-bit accumulator, cleared on sync.
  - Checksum = sum of the 16 image bytes mod 256, excluding the sync byte.
  - One extra checksum byte is expected after the image; a mismatch leaves the CPU halted with `err`=1.
- Undefined: no accumulator and no `CHECK` state. `RUN` is entered directly after byte 16.

## Test plan
- Load: send A5, then 00..0F as bytes 8'h10 + i, with `CLKS_PER_BIT`=16. Require `loading`=1 throughout, then `cpu_run`=1 one cycle after the 16th byte, and `data`=8'h1F at `addr`=4'hF. With checksum enabled, append 8'h78.
- Glitch: `rx` low for 5 cycles in `IDLE`. Require no byte received and the state unchanged.
- Framing error: at byte 7 of a load, send a byte with stop bit 0. Require `err`=1, `cpu_run`=0, `loading`=0. A later A5 clears `err`.
- Reload: in `RUN`, send A5. Require `cpu_run`=0 and `loading`=1 within one cycle of the byte being accepted. Loading 16 8'hFF bytes then returns to `RUN` with `data`=8'hFF at every address.
- Reset mid-load: assert `reset` after 9 bytes. Require every output at its reset value, all `mem` = 8'h00, and the next non-A5 byte ignored.
- Checksum (macro on): send the correct image with checksum 8'h00 in place of the correct value. Require `err`=1 and `cpu_run`=0.
